// File: rtl/neuron_pkg.sv
// Shared types for the neuron trainer: sample field widths, the packed
// sample record stored by the feeder, and the feeder FSM state encoding.
package neuron_pkg;

    localparam int unsigned X_W      = 7;
    localparam int unsigned T_W      = 2;
    localparam int unsigned SAMPLE_W = 2 * X_W + T_W;

    typedef struct packed {
        logic signed [X_W-1:0] x1;
        logic signed [X_W-1:0] x2;
        logic signed [T_W-1:0] t;
    } sample_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        SEND     = 2'd2,
        FINISHED = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sample_ram.sv
// Training-set storage: DEPTH x W array, one write port, one read port with
// a registered read-data output. Contents are not reset.
//   clk   : clock
//   we    : write enable, writes wdata to waddr
//   waddr : write address
//   wdata : write data
//   raddr : read address, captured into rdata every edge
//   rdata : registered read data
module sample_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned W     = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_feeder.sv
// Sample feeder: stores a training set of (x1, x2, t) samples loaded one per
// cycle and replays them in order to the neuron over the requestFlag /
// dataReady handshake, wrapping each epoch until the neuron signals done.
//   clk, rst          : clock, asynchronous active-high reset
//   loadValid         : append loadX1/loadX2/loadT to the set (IDLE only)
//   start             : begin replay (IDLE) or clear the set (FINISHED)
//   requestFlag, done : neuron handshake inputs
//   x1Out, x2Out, tOut: sample presented to the neuron, valid with dataReady
//   dataReady         : one-cycle strobe per issued sample
//   nOut              : stored sample count, zero-extended
//   epoch             : completed passes over the set, saturating
//   busy, full        : status flags
//   overflow          : sticky, load attempted while full
//   emptyStart        : sticky, start seen with an empty set
module sample_feeder
    import neuron_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        loadValid,
    input  logic [6:0]  loadX1,
    input  logic [6:0]  loadX2,
    input  logic [1:0]  loadT,
    input  logic        start,
    input  logic        requestFlag,
    input  logic        done,
    output logic [6:0]  x1Out,
    output logic [6:0]  x2Out,
    output logic [1:0]  tOut,
    output logic        dataReady,
    output logic [31:0] nOut,
    output logic [15:0] epoch,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    output logic        emptyStart
);

    localparam int unsigned CW      = AW + 1;
    localparam int unsigned EPOCH_W = 16;

    feeder_state_t        state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        rdptr_q, rdptr_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic                 overflow_q, overflow_d;
    logic                 empty_q, empty_d;
    logic                 wr_en_c;
    logic                 send_c;
    logic                 last_c;
    sample_t              wr_sample;
    sample_t              rd_sample;
    logic [SAMPLE_W-1:0]  rd_data;

    assign wr_sample = '{x1: loadX1, x2: loadX2, t: loadT};
    assign rd_sample = sample_t'(rd_data);
    assign last_c    = ({1'b0, rdptr_q} == (count_q - CW'(1)));

    // Read address follows the next pointer so the registered read data
    // always holds memory[rdPtr] by the time a request is sampled.
    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_c),
        .waddr (count_q[AW-1:0]),
        .wdata (wr_sample),
        .raddr (rdptr_d),
        .rdata (rd_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pointer, count and epoch logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rdptr_d    = rdptr_q;
        epoch_d    = epoch_q;
        overflow_d = overflow_q;
        empty_d    = empty_q;
        wr_en_c    = 1'b0;
        send_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (loadValid) begin
                    if (count_q == CW'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_en_c = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
                if (start) begin
                    if (count_q != '0) begin
                        rdptr_d = '0;
                        epoch_d = '0;
                        state_d = WAIT_REQ;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end

            WAIT_REQ: begin
                // done wins over a simultaneous request
                if (done) begin
                    state_d = FINISHED;
                end else if (requestFlag) begin
                    send_c  = 1'b1;
                    state_d = SEND;
                    if (last_c) begin
                        rdptr_d = '0;
                        epoch_d = (epoch_q == '1) ? epoch_q : epoch_q + EPOCH_W'(1);
                    end else begin
                        rdptr_d = rdptr_q + AW'(1);
                    end
                end
            end

            SEND: begin
                state_d = WAIT_REQ;
            end

            FINISHED: begin
                if (start) begin
                    overflow_d = 1'b0;
                    empty_d    = 1'b0;
                    count_d    = '0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            rdptr_q    <= '0;
            epoch_q    <= '0;
            overflow_q <= 1'b0;
            empty_q    <= 1'b0;
            dataReady  <= 1'b0;
            busy       <= 1'b0;
            full       <= 1'b0;
            x1Out      <= '0;
            x2Out      <= '0;
            tOut       <= '0;
        end else begin
            count_q    <= count_d;
            rdptr_q    <= rdptr_d;
            epoch_q    <= epoch_d;
            overflow_q <= overflow_d;
            empty_q    <= empty_d;
            dataReady  <= send_c;
            busy       <= (state_d == WAIT_REQ) || (state_d == SEND);
            full       <= (count_d == CW'(DEPTH));
            if (send_c) begin
                x1Out <= rd_sample.x1;
                x2Out <= rd_sample.x2;
                tOut  <= rd_sample.t;
            end
        end
    end

    assign nOut       = 32'(count_q);
    assign epoch      = epoch_q;
    assign overflow   = overflow_q;
    assign emptyStart = empty_q;

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic        loadValid;
    logic [6:0]  loadX1;
    logic [6:0]  loadX2;
    logic [1:0]  loadT;
    logic        start;
    logic        requestFlag;
    logic        done;
    logic [6:0]  x1Out;
    logic [6:0]  x2Out;
    logic [1:0]  tOut;
    logic        dataReady;
    logic [31:0] nOut;
    logic [15:0] epoch;
    logic        busy;
    logic        full;
    logic        overflow;
    logic        emptyStart;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sample_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .loadValid   (loadValid),
        .loadX1      (loadX1),
        .loadX2      (loadX2),
        .loadT       (loadT),
        .start       (start),
        .requestFlag (requestFlag),
        .done        (done),
        .x1Out       (x1Out),
        .x2Out       (x2Out),
        .tOut        (tOut),
        .dataReady   (dataReady),
        .nOut        (nOut),
        .epoch       (epoch),
        .busy        (busy),
        .full        (full),
        .overflow    (overflow),
        .emptyStart  (emptyStart)
    );

    typedef struct {
        logic lv;
        int   x1, x2, t;
        logic st, rq, dn;
        logic edr;
        int   ex1, ex2, et, en;
        logic eb;
        int   ep;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mkv(input logic lv, input int x1, input int x2, input int t,
                                 input logic st, input logic rq, input logic dn,
                                 input logic edr, input int ex1, input int ex2, input int et,
                                 input int en, input logic eb, input int ep);
        vec_t v;
        v.lv = lv; v.x1 = x1; v.x2 = x2; v.t = t;
        v.st = st; v.rq = rq; v.dn = dn;
        v.edr = edr; v.ex1 = ex1; v.ex2 = ex2; v.et = et;
        v.en = en; v.eb = eb; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input int x1, input int x2, input int t,
                         input logic st, input logic rq, input logic dn);
        loadValid   = lv;
        loadX1      = 7'(x1);
        loadX2      = 7'(x2);
        loadT       = 2'(t);
        start       = st;
        requestFlag = rq;
        done        = dn;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int sx(input int v);
        logic signed [6:0] s;
        s = 7'(v);
        return int'(s);
    endfunction

    // Sample model for the capacity test; overflow-phase loads use a distinct pattern
    function automatic int mx1(input int i);
        return (i < int'(DEPTH)) ? sx(i) : 0;
    endfunction
    function automatic int mx2(input int i);
        return (i < int'(DEPTH)) ? sx(i >> 2) : 0;
    endfunction
    function automatic int mt(input int i);
        return (i < int'(DEPTH)) ? ((i % 2 == 1) ? -1 : 1) : 1;
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        #2;
        // Asynchronous reset state
        check("rst_dataReady", int'(dataReady), 0);
        check("rst_nOut", int'(nOut), 0);
        check("rst_x1Out", int'(x1Out), 0);
        check("rst_tOut", int'(tOut), 0);
        check("rst_epoch", int'(epoch), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_full", int'(full), 0);
        check("rst_flags", int'({overflow, emptyStart}), 0);
        step();
        rst = 1'b0;

        // Three-sample replay, wrap, loads while running, done, clear
        tbl[0]  = mkv(1,  5, -3,  1, 0, 0, 0,  0, 0,  0,  0, 1, 0, 0);
        tbl[1]  = mkv(1, -7,  2, -1, 0, 0, 0,  0, 0,  0,  0, 2, 0, 0);
        tbl[2]  = mkv(1,  0, 63,  1, 0, 0, 0,  0, 0,  0,  0, 3, 0, 0);
        tbl[3]  = mkv(0,  0,  0,  0, 1, 0, 0,  0, 0,  0,  0, 3, 1, 0);
        tbl[4]  = mkv(0,  0,  0,  0, 0, 1, 0,  1, 5, -3,  1, 3, 1, 0);
        tbl[5]  = mkv(0,  0,  0,  0, 0, 0, 0,  0, 5, -3,  1, 3, 1, 0);
        tbl[6]  = mkv(0,  0,  0,  0, 0, 0, 0,  0, 5, -3,  1, 3, 1, 0);
        tbl[7]  = mkv(0,  0,  0,  0, 0, 1, 0,  1, -7, 2, -1, 3, 1, 0);
        tbl[8]  = mkv(0,  0,  0,  0, 0, 0, 0,  0, -7, 2, -1, 3, 1, 0);
        tbl[9]  = mkv(0,  0,  0,  0, 0, 0, 0,  0, -7, 2, -1, 3, 1, 0);
        tbl[10] = mkv(0,  0,  0,  0, 0, 1, 0,  1, 0, 63,  1, 3, 1, 1);
        tbl[11] = mkv(0,  0,  0,  0, 0, 0, 0,  0, 0, 63,  1, 3, 1, 1);
        tbl[12] = mkv(0,  0,  0,  0, 0, 0, 0,  0, 0, 63,  1, 3, 1, 1);
        tbl[13] = mkv(0,  0,  0,  0, 0, 1, 0,  1, 5, -3,  1, 3, 1, 1);
        tbl[14] = mkv(1,  9,  9,  1, 0, 0, 0,  0, 5, -3,  1, 3, 1, 1);
        tbl[15] = mkv(1,  9,  9,  1, 0, 0, 0,  0, 5, -3,  1, 3, 1, 1);
        tbl[16] = mkv(0,  0,  0,  0, 0, 0, 1,  0, 5, -3,  1, 3, 0, 1);
        tbl[17] = mkv(1,  9,  9,  1, 0, 0, 0,  0, 5, -3,  1, 3, 0, 1);
        tbl[18] = mkv(0,  0,  0,  0, 1, 0, 0,  0, 5, -3,  1, 0, 0, 1);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].lv, tbl[i].x1, tbl[i].x2, tbl[i].t, tbl[i].st, tbl[i].rq, tbl[i].dn);
            step();
            check($sformatf("row%0d_dataReady", i), int'(dataReady), int'(tbl[i].edr));
            check($sformatf("row%0d_x1Out", i), sx(int'(x1Out)), tbl[i].ex1);
            check($sformatf("row%0d_x2Out", i), sx(int'(x2Out)), tbl[i].ex2);
            check($sformatf("row%0d_tOut", i), int'($signed(tOut)), tbl[i].et);
            check($sformatf("row%0d_nOut", i), int'(nOut), tbl[i].en);
            check($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].eb));
            check($sformatf("row%0d_epoch", i), int'(epoch), tbl[i].ep);
            check($sformatf("row%0d_overflow", i), int'(overflow), 0);
        end

        // Start with an empty set
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        check("empty_emptyStart", int'(emptyStart), 1);
        check("empty_busy", int'(busy), 0);
        check("empty_dataReady", int'(dataReady), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        check("empty_req_dataReady", int'(dataReady), 0);
        check("empty_req_busy", int'(busy), 0);
        idle();

        // Capacity: DEPTH+2 loads
        do_reset();
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            drive(1, mx1(i), mx2(i), mt(i), 0, 0, 0);
            step();
            if (i == int'(DEPTH) - 2) check("cap_full_before", int'(full), 0);
            if (i == int'(DEPTH) - 1) begin
                check("cap_full_at", int'(full), 1);
                check("cap_ovf_at", int'(overflow), 0);
            end
        end
        idle();
        check("cap_overflow", int'(overflow), 1);
        check("cap_nOut", int'(nOut), int'(DEPTH));
        check("cap_full", int'(full), 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            step();
            check($sformatf("cap%0d_dataReady", i), int'(dataReady), 1);
            check($sformatf("cap%0d_x1Out", i), sx(int'(x1Out)), mx1(i));
            check($sformatf("cap%0d_x2Out", i), sx(int'(x2Out)), mx2(i));
            check($sformatf("cap%0d_tOut", i), int'($signed(tOut)), mt(i));
            idle();
            step();
        end
        check("cap_epoch", int'(epoch), 1);

        // Single-sample set: every request returns sample 0 and bumps epoch
        do_reset();
        drive(1, 3, 4, -1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            step();
            check($sformatf("one%0d_x1Out", i), sx(int'(x1Out)), 3);
            check($sformatf("one%0d_tOut", i), int'($signed(tOut)), -1);
            check($sformatf("one%0d_epoch", i), int'(epoch), i);
            idle();
            step();
        end

        // done and requestFlag at the same edge; sticky flag clear on restart
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        check("done_pre_emptyStart", int'(emptyStart), 1);
        drive(1, 1, 1, 1, 0, 0, 0);
        step();
        drive(1, 2, 2, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        check("done_running_busy", int'(busy), 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        step();
        check("done_dataReady", int'(dataReady), 0);
        check("done_busy", int'(busy), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        check("done_late_req_dataReady", int'(dataReady), 0);
        check("done_hold_nOut", int'(nOut), 2);
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        check("done_restart_nOut", int'(nOut), 0);
        check("done_restart_emptyStart", int'(emptyStart), 0);
        check("done_restart_busy", int'(busy), 0);
        step();
        check("done_restart_no_replay", int'(busy), 0);

        // requestFlag held high for 10 cycles with 4 samples
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, -10 - i, 1, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        begin
            int pulses;
            int k;
            pulses = 0;
            k = 0;
            drive(0, 0, 0, 0, 0, 1, 0);
            for (int c = 0; c < 10; c++) begin
                step();
                check($sformatf("hold%0d_dataReady", c), int'(dataReady), (c % 2 == 0) ? 1 : 0);
                if (dataReady) begin
                    check($sformatf("hold%0d_x1Out", c), sx(int'(x1Out)), 10 + (k % 4));
                    pulses++;
                    k++;
                end
            end
            idle();
            step();
            check("hold_tail_dataReady", int'(dataReady), 0);
            check("hold_pulses", pulses, 5);
            check("hold_epoch", int'(epoch), 1);
        end

        // Asynchronous reset while in SEND
        do_reset();
        drive(1, 20, 21, 1, 0, 0, 0);
        step();
        drive(1, 22, 23, -1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        check("arst_pre_dataReady", int'(dataReady), 1);
        check("arst_pre_x1Out", sx(int'(x1Out)), 20);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_dataReady", int'(dataReady), 0);
        check("arst_nOut", int'(nOut), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_x1Out", int'(x1Out), 0);
        check("arst_x2Out", int'(x2Out), 0);
        check("arst_tOut", int'(tOut), 0);
        check("arst_epoch", int'(epoch), 0);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        check("arst_set_discarded", int'(emptyStart), 1);
        check("arst_after_busy", int'(busy), 0);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
